// File: rtl/i2c_reg_sequencer.sv
// Expands one register read/write request into START/TX/RX/STOP commands for i2c_master_single.
// Optional NACK retry is compiled in with `define I2C_SEQ_RETRY_EN.
module i2c_reg_sequencer #(
  parameter int RETRY_MAX = 3
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       req_valid,
  output logic       req_ready,
  input  logic       req_rw,
  input  logic [6:0] req_dev,
  input  logic [7:0] req_reg,
  input  logic [7:0] req_wdata,
  output logic       rsp_valid,
  output logic       rsp_nack,
  output logic [7:0] rsp_rdata,
  output logic [1:0] m_command,
  output logic       m_start,
  output logic [7:0] m_data_w,
  output logic       m_r_ack,
  input  logic       m_w_ack,
  input  logic [7:0] m_data_r,
  input  logic       m_busy,
  output logic [2:0] dbg_state
);

  // Request handshake: a request transfers on a clock edge where req_valid && req_ready;
  // the request fields are sampled on that same edge and ignored otherwise.
  typedef enum logic [2:0] {
    S_IDLE, S_ISSUE, S_WAIT_HI, S_WAIT_LO, S_EVAL, S_DONE
  } state_t;

  localparam logic [1:0] CMD_START = 2'd0;
  localparam logic [1:0] CMD_STOP  = 2'd1;
  localparam logic [1:0] CMD_TX    = 2'd2;
  localparam logic [1:0] CMD_RX    = 2'd3;

  state_t     state_q;
  logic [2:0] step_q;
  logic       rw_q;
  logic [6:0] dev_q;
  logic [7:0] reg_q, wdata_q, rdata_q;
  logic       nack_q;
  logic       m_start_q, m_r_ack_q, rsp_valid_q, rsp_nack_q;
  logic [1:0] m_command_q;
  logic [7:0] m_data_w_q, rsp_rdata_q;

  logic [1:0] step_cmd;
  logic [7:0] step_data;
  logic       step_rack;
  logic [2:0] last_step;
  logic       retry_go;

  always_comb begin
    step_cmd  = CMD_STOP;
    step_data = 8'h00;
    step_rack = 1'b0;
    if (!rw_q) begin
      case (step_q)
        3'd0:    step_cmd = CMD_START;
        3'd1:    begin step_cmd = CMD_TX; step_data = {dev_q, 1'b0}; end
        3'd2:    begin step_cmd = CMD_TX; step_data = reg_q; end
        3'd3:    begin step_cmd = CMD_TX; step_data = wdata_q; end
        default: step_cmd = CMD_STOP;
      endcase
    end else begin
      case (step_q)
        3'd0:    step_cmd = CMD_START;
        3'd1:    begin step_cmd = CMD_TX; step_data = {dev_q, 1'b0}; end
        3'd2:    begin step_cmd = CMD_TX; step_data = reg_q; end
        3'd3:    step_cmd = CMD_START;
        3'd4:    begin step_cmd = CMD_TX; step_data = {dev_q, 1'b1}; end
        3'd5:    begin step_cmd = CMD_RX; step_rack = 1'b1; end
        default: step_cmd = CMD_STOP;
      endcase
    end
  end

  assign last_step = rw_q ? 3'd6 : 3'd4;

`ifdef I2C_SEQ_RETRY_EN
  localparam int RW = $clog2(RETRY_MAX + 1);
  logic [RW-1:0] retry_q;
  assign retry_go = nack_q && (retry_q < RW'(RETRY_MAX));
`else
  logic unused_retry_max;
  assign unused_retry_max = (RETRY_MAX > 0);
  assign retry_go = 1'b0;
`endif

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= S_IDLE;
      step_q      <= 3'd0;
      rw_q        <= 1'b0;
      dev_q       <= 7'h00;
      reg_q       <= 8'h00;
      wdata_q     <= 8'h00;
      rdata_q     <= 8'h00;
      nack_q      <= 1'b0;
      m_start_q   <= 1'b0;
      m_command_q <= 2'd0;
      m_data_w_q  <= 8'h00;
      m_r_ack_q   <= 1'b0;
      rsp_valid_q <= 1'b0;
      rsp_nack_q  <= 1'b0;
      rsp_rdata_q <= 8'h00;
`ifdef I2C_SEQ_RETRY_EN
      retry_q     <= '0;
`endif
    end else begin
      m_start_q   <= 1'b0;
      rsp_valid_q <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (req_valid && req_ready) begin
            rw_q    <= req_rw;
            dev_q   <= req_dev;
            reg_q   <= req_reg;
            wdata_q <= req_wdata;
            rdata_q <= 8'h00;
            nack_q  <= 1'b0;
            step_q  <= 3'd0;
`ifdef I2C_SEQ_RETRY_EN
            retry_q <= '0;
`endif
            state_q <= S_ISSUE;
          end
        end
        S_ISSUE: begin
          m_start_q   <= 1'b1;
          m_command_q <= step_cmd;
          m_data_w_q  <= step_data;
          m_r_ack_q   <= step_rack;
          state_q     <= S_WAIT_HI;
        end
        S_WAIT_HI: if (m_busy) state_q <= S_WAIT_LO;
        S_WAIT_LO: if (!m_busy) state_q <= S_EVAL;
        S_EVAL: begin
          if (step_q == last_step) begin
            if (retry_go) begin
`ifdef I2C_SEQ_RETRY_EN
              retry_q <= retry_q + RW'(1);
`endif
              nack_q  <= 1'b0;
              step_q  <= 3'd0;
              state_q <= S_ISSUE;
            end else begin
              rsp_valid_q <= 1'b1;
              rsp_nack_q  <= nack_q;
              rsp_rdata_q <= nack_q ? 8'h00 : rdata_q;
              state_q     <= S_DONE;
            end
          end else if (step_cmd == CMD_TX && m_w_ack) begin
            // Abort straight to STOP so the bus is always released.
            nack_q  <= 1'b1;
            step_q  <= last_step;
            state_q <= S_ISSUE;
          end else begin
            if (step_cmd == CMD_RX) rdata_q <= m_data_r;
            step_q  <= step_q + 3'd1;
            state_q <= S_ISSUE;
          end
        end
        S_DONE:  state_q <= S_IDLE;
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign req_ready = (state_q == S_IDLE) && !m_busy;
  assign m_start   = m_start_q;
  assign m_command = m_command_q;
  assign m_data_w  = m_data_w_q;
  assign m_r_ack   = m_r_ack_q;
  assign rsp_valid = rsp_valid_q;
  assign rsp_nack  = rsp_nack_q;
  assign rsp_rdata = rsp_rdata_q;
  assign dbg_state = state_q;

endmodule

// File: tb/tb_i2c_reg_sequencer.sv
// Scoreboard bench for i2c_reg_sequencer with a behavioural byte-level I2C master/slave model.
module tb_i2c_reg_sequencer;

  localparam logic [1:0] C_START = 2'd0;
  localparam logic [1:0] C_STOP  = 2'd1;
  localparam logic [1:0] C_TX    = 2'd2;
  localparam logic [1:0] C_RX    = 2'd3;

  logic       clk = 1'b0;
  logic       reset_n;
  logic       req_valid, req_ready, req_rw;
  logic [6:0] req_dev;
  logic [7:0] req_reg, req_wdata;
  logic       rsp_valid, rsp_nack;
  logic [7:0] rsp_rdata;
  logic [1:0] m_command;
  logic       m_start;
  logic [7:0] m_data_w;
  logic       m_r_ack;
  logic       m_w_ack;
  logic [7:0] m_data_r;
  logic       m_busy;
  logic [2:0] dbg_state;

  always #5 clk = ~clk;

  i2c_reg_sequencer #(.RETRY_MAX(3)) dut (
    .clk(clk), .reset_n(reset_n),
    .req_valid(req_valid), .req_ready(req_ready), .req_rw(req_rw),
    .req_dev(req_dev), .req_reg(req_reg), .req_wdata(req_wdata),
    .rsp_valid(rsp_valid), .rsp_nack(rsp_nack), .rsp_rdata(rsp_rdata),
    .m_command(m_command), .m_start(m_start), .m_data_w(m_data_w), .m_r_ack(m_r_ack),
    .m_w_ack(m_w_ack), .m_data_r(m_data_r), .m_busy(m_busy), .dbg_state(dbg_state)
  );

  int total = 0;
  int bad   = 0;
  logic [10:0] exp_q[$];      // {cmd, tx byte, r_ack}
  logic [8:0]  exp_rsp_q[$];  // {nack, rdata}

  // Slave behaviour knobs
  int         busy_len  = 3;
  int         busy_cnt  = 0;
  logic [7:0] nack_byte = 8'hA0;
  int         nack_left = 0;
  logic [7:0] rd_byte   = 8'hA5;
  logic [1:0] cur_cmd;
  logic [7:0] cur_data;
  logic       prev_start = 1'b0;
  logic [10:0] ec;
  logic [8:0]  er;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Monitor first, then the master/slave model, all on the falling edge.
  initial begin
    m_busy = 1'b0; m_w_ack = 1'b0; m_data_r = 8'h00;
    forever begin
      @(negedge clk);
      if (m_start) begin
        check("start_while_busy", 32'(m_busy), 32'd0);
        check("start_width", 32'(prev_start), 32'd0);
        if (exp_q.size() == 0) begin
          total++; bad++;
          $display("FAIL unexpected_cmd: got cmd %0d data 0x%0h, none expected", m_command, m_data_w);
        end else begin
          ec = exp_q.pop_front();
          check("cmd", 32'(m_command), 32'(ec[10:9]));
          if (ec[10:9] == C_TX) check("tx_data", 32'(m_data_w), 32'(ec[8:1]));
          if (ec[10:9] == C_RX) check("rx_ack", 32'(m_r_ack), 32'(ec[0]));
        end
      end
      prev_start = m_start;
      if (rsp_valid) begin
        if (exp_rsp_q.size() == 0) begin
          total++; bad++;
          $display("FAIL unexpected_rsp: got nack %0d rdata 0x%0h, none expected", rsp_nack, rsp_rdata);
        end else begin
          er = exp_rsp_q.pop_front();
          check("rsp_nack", 32'(rsp_nack), 32'(er[8]));
          check("rsp_rdata", 32'(rsp_rdata), 32'(er[7:0]));
        end
      end
      if (m_busy) begin
        busy_cnt--;
        if (busy_cnt <= 0) begin
          m_busy  = 1'b0;
          m_w_ack = (cur_cmd == C_TX) && (cur_data == nack_byte) && (nack_left > 0);
          if (m_w_ack) nack_left--;
          if (cur_cmd == C_RX) m_data_r = rd_byte;
        end
      end else if (m_start) begin
        m_busy   = 1'b1;
        busy_cnt = busy_len;
        cur_cmd  = m_command;
        cur_data = m_data_w;
      end
    end
  end

  task automatic push_cmd(input logic [1:0] c, input logic [7:0] d, input logic r);
    exp_q.push_back({c, d, r});
  endtask

  task automatic push_write(input logic [6:0] dev, input logic [7:0] rg, input logic [7:0] wd);
    push_cmd(C_START, 8'h00, 1'b0);
    push_cmd(C_TX, {dev, 1'b0}, 1'b0);
    push_cmd(C_TX, rg, 1'b0);
    push_cmd(C_TX, wd, 1'b0);
    push_cmd(C_STOP, 8'h00, 1'b0);
  endtask

  task automatic push_read(input logic [6:0] dev, input logic [7:0] rg);
    push_cmd(C_START, 8'h00, 1'b0);
    push_cmd(C_TX, {dev, 1'b0}, 1'b0);
    push_cmd(C_TX, rg, 1'b0);
    push_cmd(C_START, 8'h00, 1'b0);
    push_cmd(C_TX, {dev, 1'b1}, 1'b0);
    push_cmd(C_RX, 8'h00, 1'b1);
    push_cmd(C_STOP, 8'h00, 1'b0);
  endtask

  task automatic drive_req(input logic rw, input logic [6:0] dev, input logic [7:0] rg,
                           input logic [7:0] wd);
    req_valid = 1'b1; req_rw = rw; req_dev = dev; req_reg = rg; req_wdata = wd;
  endtask

  // Keeps req_valid high until an edge with req_ready, then drops it.
  task automatic finish_accept();
    int n = 0;
    while (!req_ready && n < 500) begin
      @(negedge clk); #1; n++;
    end
    check("accept_timeout", 32'(n >= 500), 32'd0);
    @(negedge clk); #1;
    req_valid = 1'b0;
  endtask

  task automatic wait_done();
    int n = 0;
    while ((exp_q.size() != 0 || exp_rsp_q.size() != 0) && n < 3000) begin
      @(negedge clk); n++;
    end
    check("done_timeout", 32'(n >= 3000), 32'd0);
    exp_q.delete();
    exp_rsp_q.delete();
    repeat (6) @(negedge clk);
    #1;
  endtask

  initial begin
    reset_n = 1'b0;
    req_valid = 1'b0; req_rw = 1'b0; req_dev = 7'h00; req_reg = 8'h00; req_wdata = 8'h00;
    repeat (3) @(negedge clk);
    #1;
    check("rst_m_start", 32'(m_start), 32'd0);
    check("rst_m_command", 32'(m_command), 32'd0);
    check("rst_m_data_w", 32'(m_data_w), 32'd0);
    check("rst_m_r_ack", 32'(m_r_ack), 32'd0);
    check("rst_rsp_valid", 32'(rsp_valid), 32'd0);
    check("rst_rsp_nack", 32'(rsp_nack), 32'd0);
    check("rst_rsp_rdata", 32'(rsp_rdata), 32'd0);
    reset_n = 1'b1;
    @(negedge clk); #1;
    check("idle_req_ready", 32'(req_ready), 32'd1);

    // Plain write, all ACK
    push_write(7'h50, 8'h10, 8'h3C);
    exp_rsp_q.push_back({1'b0, 8'h00});
    drive_req(1'b0, 7'h50, 8'h10, 8'h3C); finish_accept(); wait_done();

    // Second write with edge-value bytes
    push_write(7'h2D, 8'hFF, 8'h00);
    exp_rsp_q.push_back({1'b0, 8'h00});
    drive_req(1'b0, 7'h2D, 8'hFF, 8'h00); finish_accept(); wait_done();

    // Read returning 0xA5
    rd_byte = 8'hA5;
    push_read(7'h50, 8'h02);
    exp_rsp_q.push_back({1'b0, 8'hA5});
    drive_req(1'b1, 7'h50, 8'h02, 8'hFF); finish_accept(); wait_done();
    check("hold_rdata", 32'(rsp_rdata), 32'hA5);
    check("hold_nack0", 32'(rsp_nack), 32'd0);

    // Slave NACKs the address byte on every attempt
    nack_byte = 8'hA0; nack_left = 100;
`ifdef I2C_SEQ_RETRY_EN
    for (int g = 0; g < 4; g++) begin
`else
    for (int g = 0; g < 1; g++) begin
`endif
      push_cmd(C_START, 8'h00, 1'b0);
      push_cmd(C_TX, 8'hA0, 1'b0);
      push_cmd(C_STOP, 8'h00, 1'b0);
    end
    exp_rsp_q.push_back({1'b1, 8'h00});
    drive_req(1'b0, 7'h50, 8'h10, 8'h3C); finish_accept(); wait_done();
    check("hold_nack1", 32'(rsp_nack), 32'd1);
    check("hold_rdata_nack", 32'(rsp_rdata), 32'd0);
    nack_left = 0;

    // Read with one NACK on the register byte
    nack_byte = 8'h02; nack_left = 1; rd_byte = 8'h5A;
    push_cmd(C_START, 8'h00, 1'b0);
    push_cmd(C_TX, 8'hA0, 1'b0);
    push_cmd(C_TX, 8'h02, 1'b0);
    push_cmd(C_STOP, 8'h00, 1'b0);
`ifdef I2C_SEQ_RETRY_EN
    push_read(7'h50, 8'h02);
    exp_rsp_q.push_back({1'b0, 8'h5A});
`else
    exp_rsp_q.push_back({1'b1, 8'h00});
`endif
    drive_req(1'b1, 7'h50, 8'h02, 8'h00); finish_accept(); wait_done();
    nack_left = 0; nack_byte = 8'hA0;

`ifdef I2C_SEQ_RETRY_EN
    // Two NACKed attempts, then success
    nack_left = 2;
    for (int g = 0; g < 2; g++) begin
      push_cmd(C_START, 8'h00, 1'b0);
      push_cmd(C_TX, 8'hA0, 1'b0);
      push_cmd(C_STOP, 8'h00, 1'b0);
    end
    push_write(7'h50, 8'h10, 8'h3C);
    exp_rsp_q.push_back({1'b0, 8'h00});
    drive_req(1'b0, 7'h50, 8'h10, 8'h3C); finish_accept(); wait_done();
    nack_left = 0;
`endif

    // Reset in the middle of a long TX, with a new request already waiting
    busy_len = 20;
    push_cmd(C_START, 8'h00, 1'b0);
    push_cmd(C_TX, 8'hA0, 1'b0);
    drive_req(1'b0, 7'h50, 8'h11, 8'h22); finish_accept();
    begin
      int n = 0;
      while ((exp_q.size() != 0 || !m_busy) && n < 500) begin
        @(negedge clk); #1; n++;
      end
      check("mid_tx_reach", 32'(n >= 500), 32'd0);
    end
    busy_len = 3;
    exp_q.delete();
    reset_n = 1'b0;
    drive_req(1'b0, 7'h21, 8'h33, 8'h44);
    push_write(7'h21, 8'h33, 8'h44);
    exp_rsp_q.push_back({1'b0, 8'h00});
    @(negedge clk); #1;
    reset_n = 1'b1;
    check("rst_busy_still", 32'(m_busy), 32'd1);
    begin
      int n = 0;
      while (m_busy && n < 100) begin
        check("rst_no_start", 32'(m_start), 32'd0);
        check("rst_not_ready", 32'(req_ready), 32'd0);
        @(negedge clk); #1; n++;
      end
    end
    finish_accept(); wait_done();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #500000;
    bad++;
    $display("FAIL watchdog: simulation still running at %0t", $time);
    $display("test done: total=%0d bad=%0d", total, bad);
    $fatal(1, "watchdog expired");
  end

endmodule
